// File: rtl/bios_watchdog.sv
// LPC-attached BIOS watchdog: prescaled tick, reloadable 13-bit down-counter, and status register.
// Define BIOS_WD_AUTO_SWITCH_EN to enable automatic dual-BIOS failover on expiry.
module bios_watchdog #(
  parameter int unsigned TICK_DIV = 33000
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       WriteBiosWD,
  input  logic [7:0] DataWr,
  output logic       WdTimeout,
  output logic       BiosSel,
  output logic [7:0] WdStatus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    EXPIRED = 2'b10,
    HALT    = 2'b11
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  state_t      state, state_nxt;
  logic [12:0] counter, counter_nxt;
  logic [15:0] prescaler, prescaler_nxt;
  logic [1:0]  sel, sel_nxt;
  logic        enable, enable_nxt;
  logic        timeout_flag, timeout_flag_nxt;
  logic [1:0]  switch_count, switch_count_nxt;
  logic        bios_sel, bios_sel_nxt;
  logic        wd_timeout;
  logic [7:0]  wd_status;

  logic tick;
  logic wr_on;
  logic wr_off;
  logic kick;
  logic unused_data;

  assign tick        = (prescaler == TICK_LAST);
  assign wr_on       = WriteBiosWD & DataWr[7];
  assign wr_off      = WriteBiosWD & ~DataWr[7];
  assign kick        = DataWr[6];
  assign unused_data = ^DataWr[3:0];

  function automatic logic [12:0] reload_ticks(input logic [1:0] s);
    logic [12:0] n;
    case (s)
      2'b00:   n = 13'd1000;
      2'b01:   n = 13'd2000;
      2'b10:   n = 13'd4000;
      default: n = 13'd8000;
    endcase
    return n;
  endfunction

  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      state        <= IDLE;
      counter      <= 13'd0;
      prescaler    <= 16'd0;
      sel          <= 2'b00;
      enable       <= 1'b0;
      timeout_flag <= 1'b0;
      switch_count <= 2'b00;
      bios_sel     <= 1'b0;
      wd_timeout   <= 1'b0;
      wd_status    <= 8'h00;
    end else begin
      state        <= state_nxt;
      counter      <= counter_nxt;
      prescaler    <= prescaler_nxt;
      sel          <= sel_nxt;
      enable       <= enable_nxt;
      timeout_flag <= timeout_flag_nxt;
      switch_count <= switch_count_nxt;
      bios_sel     <= bios_sel_nxt;
      wd_timeout   <= (state_nxt == EXPIRED);
      wd_status    <= {enable_nxt, timeout_flag_nxt, sel_nxt, state_nxt, switch_count_nxt};
    end
  end

  // A disabling write overrides everything else, including a pending expiry.
  always_comb begin
    state_nxt        = state;
    counter_nxt      = counter;
    prescaler_nxt    = prescaler;
    sel_nxt          = sel;
    enable_nxt       = enable;
    timeout_flag_nxt = timeout_flag;
    switch_count_nxt = switch_count;
    bios_sel_nxt     = bios_sel;

    if (wr_off) begin
      state_nxt        = IDLE;
      counter_nxt      = 13'd0;
      prescaler_nxt    = 16'd0;
      timeout_flag_nxt = 1'b0;
      switch_count_nxt = 2'b00;
      enable_nxt       = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          prescaler_nxt = 16'd0;
          if (wr_on) begin
            sel_nxt     = DataWr[5:4];
            counter_nxt = reload_ticks(DataWr[5:4]);
            enable_nxt  = 1'b1;
            state_nxt   = ARMED;
          end
        end

        ARMED: begin
          prescaler_nxt = tick ? 16'd0 : prescaler + 16'd1;
          if (wr_on) begin
            sel_nxt = DataWr[5:4];
          end
          // A kick on the expiring tick still reloads, so it is checked first.
          if (wr_on && kick) begin
            counter_nxt   = reload_ticks(DataWr[5:4]);
            prescaler_nxt = 16'd0;
          end else if (tick) begin
            if (counter <= 13'd1) begin
              counter_nxt      = 13'd0;
              timeout_flag_nxt = 1'b1;
              state_nxt        = EXPIRED;
            end else begin
              counter_nxt = counter - 13'd1;
            end
          end
        end

        EXPIRED: begin
          prescaler_nxt = 16'd0;
`ifdef BIOS_WD_AUTO_SWITCH_EN
          bios_sel_nxt     = ~bios_sel;
          switch_count_nxt = (switch_count == 2'd3) ? 2'd3 : switch_count + 2'd1;
          if (switch_count_nxt < 2'd2) begin
            counter_nxt = reload_ticks(sel);
            state_nxt   = ARMED;
          end else begin
            counter_nxt = 13'd0;
            state_nxt   = HALT;
          end
`else
          counter_nxt = 13'd0;
          state_nxt   = HALT;
`endif
        end

        default: begin
          counter_nxt   = 13'd0;
          prescaler_nxt = 16'd0;
        end
      endcase
    end
  end

  assign WdTimeout = wd_timeout;
  assign BiosSel   = bios_sel;
  assign WdStatus  = wd_status;

endmodule

// File: tb/tb_bios_watchdog.sv
// Randomized and scenario-driven bench for bios_watchdog, checked every cycle against
// a deadline-based reference model (expiry cycle = write cycle + N * TICK_DIV).
module tb_bios_watchdog;

  localparam int TICK_DIV = 4;

  logic       LpcClock = 1'b0;
  logic       PciReset = 1'b1;
  logic       WriteBiosWD = 1'b0;
  logic [7:0] DataWr = 8'h00;
  logic       WdTimeout;
  logic       BiosSel;
  logic [7:0] WdStatus;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;

  int m_state = 0;
  int m_deadline = 0;
  int m_sel = 0;
  int m_en = 0;
  int m_flag = 0;
  int m_sw = 0;
  int m_bios = 0;

  always #5 LpcClock = ~LpcClock;

  bios_watchdog #(.TICK_DIV(TICK_DIV)) dut (
    .LpcClock   (LpcClock),
    .PciReset   (PciReset),
    .WriteBiosWD(WriteBiosWD),
    .DataWr     (DataWr),
    .WdTimeout  (WdTimeout),
    .BiosSel    (BiosSel),
    .WdStatus   (WdStatus)
  );

  function automatic int reload_ticks(input int s);
    return 1000 << s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Reference behaviour at one rising edge; state codes 0..3 are the status encoding.
  task automatic model_edge(input bit rst, input bit wr, input bit [7:0] d);
    if (rst) begin
      m_state = 0; m_sel = 0; m_en = 0; m_flag = 0; m_sw = 0; m_bios = 0;
    end else if (wr && !d[7]) begin
      m_state = 0; m_flag = 0; m_sw = 0; m_en = 0;
    end else begin
      case (m_state)
        0: if (wr) begin
          m_sel = int'(d[5:4]);
          m_en = 1;
          m_deadline = cyc + reload_ticks(m_sel) * TICK_DIV;
          m_state = 1;
        end
        1: begin
          if (wr) m_sel = int'(d[5:4]);
          if (wr && d[6]) m_deadline = cyc + reload_ticks(m_sel) * TICK_DIV;
          else if (cyc == m_deadline) begin
            m_state = 2;
            m_flag = 1;
          end
        end
        2: begin
`ifdef BIOS_WD_AUTO_SWITCH_EN
          m_bios = 1 - m_bios;
          if (m_sw < 3) m_sw++;
          if (m_sw < 2) begin
            m_deadline = cyc + reload_ticks(m_sel) * TICK_DIV;
            m_state = 1;
          end else m_state = 3;
`else
          m_state = 3;
`endif
        end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit wr, input bit [7:0] d);
    int exp_status;
    PciReset = rst;
    WriteBiosWD = wr;
    DataWr = d;
    @(posedge LpcClock);
    cyc++;
    model_edge(rst, wr, d);
    @(negedge LpcClock);
    exp_status = (m_en << 7) | (m_flag << 6) | (m_sel << 4) | (m_state << 2) | m_sw;
    if (WdTimeout === 1'b1) pulses++;
    checkOutput("timeout", 32'(WdTimeout), (m_state == 2) ? 32'd1 : 32'd0);
    checkOutput("bios_sel", 32'(BiosSel), 32'(m_bios));
    checkOutput("status", 32'(WdStatus), 32'(exp_status));
    PciReset = 1'b0;
    WriteBiosWD = 1'b0;
    DataWr = 8'h00;
  endtask

  task automatic run_idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  // Edges from now until WdTimeout is seen high; -1 if the bound runs out.
  task automatic wait_pulse(input int max_cycles, output int k);
    bit found = 0;
    k = 0;
    while (!found && k < max_cycles) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      k++;
      if (WdTimeout === 1'b1) found = 1;
    end
    if (!found) k = -1;
  endtask

  initial begin
    int k;
    int p0;
    bit [7:0] d;

    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("reset_status", 32'(WdStatus), 32'h00);

    applyStimulus(1'b0, 1'b1, 8'h80);
    checkOutput("arm_status", 32'(WdStatus), 32'h84);
    wait_pulse(4100, k);
    checkOutput("latency_1000", k, 4000);
    run_idle(1);
`ifdef BIOS_WD_AUTO_SWITCH_EN
    checkOutput("after_expiry_status", 32'(WdStatus), 32'hC5);
    checkOutput("after_expiry_bios", 32'(BiosSel), 32'd1);
`else
    checkOutput("halt_status", 32'(WdStatus), 32'hCC);
    checkOutput("halt_bios", 32'(BiosSel), 32'd0);
`endif
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("disable_status", 32'(WdStatus), 32'h00);

    applyStimulus(1'b0, 1'b1, 8'h80);
    p0 = pulses;
    repeat (10) begin
      run_idle(2999);
      applyStimulus(1'b0, 1'b1, 8'hC0);
    end
    checkOutput("kick_no_timeout", pulses - p0, 0);
    checkOutput("kick_state", 32'(WdStatus[3:2]), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h00);

    applyStimulus(1'b0, 1'b1, 8'h80);
    p0 = pulses;
    run_idle(3999);
    applyStimulus(1'b0, 1'b1, 8'hC0);
    checkOutput("race_no_timeout", pulses - p0, 0);
    wait_pulse(4100, k);
    checkOutput("race_next_expiry", k, 4000);
    applyStimulus(1'b0, 1'b1, 8'h00);

    applyStimulus(1'b0, 1'b1, 8'h90);
    wait_pulse(8100, k);
    checkOutput("latency_2000", k, 8000);
`ifdef BIOS_WD_AUTO_SWITCH_EN
    run_idle(1);
    checkOutput("switch1_bios", 32'(BiosSel), 32'(1 - int'(BiosSel == 1'b0)));
    checkOutput("switch1_count", 32'(WdStatus[1:0]), 32'd1);
    wait_pulse(8100, k);
    checkOutput("second_expiry", k, 8000);
    run_idle(1);
    checkOutput("switch2_status", 32'(WdStatus), 32'hDE);
`else
    run_idle(1);
    checkOutput("halt_sel01_status", 32'(WdStatus), 32'hDC);
`endif
    applyStimulus(1'b0, 1'b1, 8'h00);

    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h80);
    run_idle(1999);
    applyStimulus(1'b1, 1'b1, 8'hC0);
    checkOutput("reset_armed_status", 32'(WdStatus), 32'h00);
    checkOutput("reset_armed_bios", 32'(BiosSel), 32'd0);
    p0 = pulses;
    run_idle(10000);
    checkOutput("reset_no_timeout", pulses - p0, 0);

    applyStimulus(1'b0, 1'b1, 8'h80);
    run_idle(3999);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("reset_at_expiry", 32'(WdTimeout), 32'd0);
    run_idle(5);

    repeat (8000) begin
      if ($urandom_range(0, 2999) == 0) applyStimulus(1'b1, 1'b0, 8'h00);
      else if ($urandom_range(0, 599) == 0) begin
        d = 8'($urandom);
        d[7] = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 3) != 0) d[5:4] = 2'b00;
        applyStimulus(1'b0, 1'b1, d);
      end else applyStimulus(1'b0, 1'b0, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

●

// File: doc/bios_watchdog.md
BIOS_WATCHDOG -- requirements
Module: BiosWatchDog

Interface
REQ-001 SHALL have parameter TICK_DIV, default 33000, meaning LpcClock cycles per watchdog tick (1 ms at 33 MHz); legal range 2..65535.
REQ-002 SHALL have port LpcClock, input, 1, the only clock; all logic on its rising edge.
REQ-003 SHALL have port PciReset, input, 1, reset; one clock, and PciReset is synchronous and active-high.
REQ-004 SHALL have port WriteBiosWD, input, 1, single-cycle strobe: LPC write to the watchdog register (address 8'h01).
REQ-005 SHALL have port DataWr, input, 8, LPC write data, valid in the WriteBiosWD cycle.
REQ-006 SHALL have port WdTimeout, output, 1, one-cycle pulse on expiry.
REQ-007 SHALL have port BiosSel, output, 1, active BIOS flash select (0 = primary).
REQ-008 SHALL have port WdStatus, output, 8, read-back status for the register mux.

Function
REQ-009 SHALL decode DataWr as follows: [7] Enable, [6] Kick, [5:4] Sel, [3:0] ignored.
REQ-010 SHALL map Sel to reload ticks N as follows: 00 = 1000, 01 = 2000, 10 = 4000, 11 = 8000; the 13-bit down-counter holds N.
REQ-011 SHALL generate Tick from a prescaler counting 0..TICK_DIV-1: Tick = 1 when the prescaler equals TICK_DIV-1, and the prescaler wraps to 0 on that cycle.
REQ-012 SHALL clear the prescaler to 0 on every counter load.
REQ-013 SHALL implement a four-state FSM: IDLE=00, ARMED=01, EXPIRED=10, HALT=11.
REQ-014 SHALL, on any write with Enable=0 and from any state, go to IDLE, clear the counter, prescaler, TimeoutFlag and SwitchCount, and leave BiosSel unchanged.
REQ-015 SHALL, in IDLE, on a write with Enable=1, latch Sel, load N, and go to ARMED.
REQ-016 SHALL, in ARMED, on a write with Enable=1 and Kick=1, latch Sel and reload N.
REQ-017 SHALL, in ARMED, on a write with Enable=1 and Kick=0, latch Sel only; the new N applies at the next load.
REQ-018 SHALL, in ARMED, decrement the counter by 1 on each Tick.
REQ-019 SHALL, in ARMED, on a Tick with counter = 1, set the counter to 0 and go to EXPIRED.
REQ-020 SHALL let a Kick write win when it coincides with the Tick that would expire the counter: reload, stay ARMED, no WdTimeout.
REQ-021 SHALL, in EXPIRED, assert WdTimeout for exactly one cycle, set TimeoutFlag=1 (sticky), and leave on the next edge per REQ-030/031.
REQ-022 SHALL, in HALT, hold the counter at 0 and ignore Tick; only REQ-014 exits HALT.
REQ-023 SHALL take writes arriving in EXPIRED as follows: Enable=0 follows REQ-014; Enable=1 writes are ignored.
REQ-024 SHALL produce latency of N*TICK_DIV cycles from the arming write edge to the edge that enters EXPIRED; WdTimeout is high in the cycle after that edge.
REQ-025 SHALL drive WdStatus as a registered value: [7] Enable, [6] TimeoutFlag, [5:4] latched Sel, [3:2] FSM state, [1:0] SwitchCount (2-bit, saturating at 3).

Reset
REQ-026 SHALL, with PciReset=1 at a clock edge, set FSM=IDLE, counter=0, prescaler=0, Sel=00, TimeoutFlag=0, SwitchCount=0, BiosSel=0, WdTimeout=0, WdStatus=8'h00.
REQ-027 SHALL let reset override a simultaneous WriteBiosWD.
REQ-028 SHALL, when reset is asserted in ARMED or EXPIRED, return to IDLE with no WdTimeout pulse, including when reset is asserted in the EXPIRED cycle.

Configuration
REQ-029 SHALL use macro BIOS_WD_AUTO_SWITCH_EN to enable automatic dual-BIOS failover.
REQ-030 SHALL, with BIOS_WD_AUTO_SWITCH_EN defined, on EXPIRED: toggle BiosSel and increment SwitchCount. If the new SwitchCount < 2, reload N and return to ARMED; otherwise go to HALT.
REQ-031 SHALL, without BIOS_WD_AUTO_SWITCH_EN, go from EXPIRED to HALT, hold BiosSel constant at 0, and hold SwitchCount constant at 0.

Verification (TICK_DIV=4)
REQ-032 SHALL cover: reset, then write 8'h80 -> WdStatus=8'h84 and WdTimeout high exactly 4000 cycles after the write edge, plus one cycle.
REQ-033 SHALL cover: arm 8'h80, then write 8'hC0 every 3000 cycles, ten times -> WdTimeout never asserts and the state stays 01.
REQ-034 SHALL cover: arm 8'h80, then write 8'hC0 in the cycle of the 1000th Tick -> no WdTimeout, and the next expiry occurs 4000 cycles later.
REQ-035 SHALL cover: with the macro, arm 8'h90 -> WdTimeout at 8000 cycles, BiosSel=1, SwitchCount=1; a second pulse 8000 cycles later gives BiosSel=0, SwitchCount=2, state HALT, WdStatus=8'hDE.
REQ-036 SHALL cover: without the macro, arm 8'h80 and let it expire -> state HALT, BiosSel=0, WdStatus=8'hCC; then write 8'h00 -> WdStatus=8'h00 next cycle.
REQ-037 SHALL cover: arm 8'h80, assert PciReset at cycle 2000 -> all outputs at reset values; no WdTimeout within 10000 further cycles.
